// File: rtl/counter_seq_pkg.sv
// Purpose: shared types and constants for the counter sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_seq_pkg;

  // Default counter width; must match the counter's counter_out.
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOME = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_seq_ctrl_step.sv
// Purpose: checks that every enabled cycle moved the counter by exactly +/-1.
// Latency: step_err is combinational from count_in against last cycle's registers.
// Backpressure: none; observes only.
//
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   enable, dir  counter enable/direction driven in the current cycle
//   count_in     current counter value
//   step_err     previous cycle was enabled and count_in != prev +/- 1
module count_step_checker
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic [WIDTH-1:0] count_in,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] prev_count;
  logic             prev_en;
  logic [WIDTH-1:0] expected;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_count <= '0;
      prev_en    <= 1'b0;
    end else begin
      prev_count <= count_in;
      prev_en    <= enable;
    end
  end

  // Modular arithmetic: wrap through 0 / all-ones is a legal step.
  always_comb begin
    expected = dir ? (prev_count + ONE) : (prev_count - ONE);
  end

  assign step_err = prev_en && (count_in != expected);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Purpose: sequences an up/down counter to a commanded target (shortest path) or home.
// Latency: move of distance d -> done at accept+d+2; home -> done at accept+2.
// Backpressure: cmd_ready only in IDLE; cmd_valid ignored otherwise, no queueing.
//
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_home, cmd_target             command payload (home, or move to target)
//   count_in                         counter_out of the controlled counter
//   cnt_rst, cnt_enable, cnt_dir     drives to the counter
//   busy, done, err                  status: in progress, completion pulse, sticky error
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_home,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_rst,
  output logic             cnt_enable,
  output logic             cnt_dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] target_q;
  logic             home_q;
  logic             dir_q;
  logic             err_q;

  logic             accept;
  logic             at_target;
  logic             step_err;
  logic             err_set;
  logic [WIDTH-1:0] diff;

  // Ready is suppressed while reset is held so nothing is accepted during reset.
  assign cmd_ready = (state == IDLE) && rst;
  assign accept    = cmd_valid && cmd_ready;
  assign diff      = cmd_target - count_in;
  assign at_target = (count_in == target_q);

  count_step_checker #(
    .WIDTH (WIDTH)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .enable   (cnt_enable),
    .dir      (dir_q),
    .count_in (count_in),
    .step_err (step_err)
  );

  always_comb begin
    state_nxt  = state;
    cnt_enable = 1'b0;
    cnt_rst    = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = cmd_home ? HOME : RUN;
      end
      RUN: begin
        // A bad step stops the counter in the same cycle it is detected.
        if (step_err) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end else if (at_target) begin
          state_nxt = DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      HOME: begin
        cnt_rst   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        // The counter has had one edge to honour cnt_rst; it must read zero now.
        if (home_q && (count_in != '0)) err_set = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      target_q <= '0;
      home_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        target_q <= cmd_target;
        home_q   <= cmd_home;
        // Exactly half-way goes up.
        dir_q    <= (diff <= HALF);
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign cnt_dir = dir_q;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  // err is visible in the detecting cycle and held thereafter.
  assign err     = err_q | err_set;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Purpose: directed self-checking bench for counter_seq_ctrl with a behavioural counter.
// Latency: n/a.
// Backpressure: n/a.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_home = 1'b0;
  logic [W-1:0] cmd_target = '0;
  logic [W-1:0] count_in;
  logic         cnt_rst;
  logic         cnt_enable;
  logic         cnt_dir;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_home   (cmd_home),
    .cmd_target (cmd_target),
    .count_in   (count_in),
    .cnt_rst    (cnt_rst),
    .cnt_enable (cnt_enable),
    .cnt_dir    (cnt_dir),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Behavioural counter; hold_fault makes it ignore enable.
  logic [W-1:0] cnt = '0;
  logic         hold_fault = 1'b0;
  always @(posedge clk) begin
    if (cnt_rst) cnt <= '0;
    else if (cnt_enable && !hold_fault) cnt <= cnt_dir ? (cnt + ONE) : (cnt - ONE);
  end
  assign count_in = cnt;

  typedef struct {
    int           done_cyc;
    int           steps;
    int           rsts;
    logic [W-1:0] final_cnt;
    logic         dir;
    logic         err;
    int           err_rise;
    logic         en_at_rise;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;

  function automatic exp_t mk(input int done_cyc, input int steps, input int rsts,
                              input logic [W-1:0] final_cnt, input logic dir,
                              input logic e, input int err_rise);
    exp_t r;
    r.done_cyc   = done_cyc;
    r.steps      = steps;
    r.rsts       = rsts;
    r.final_cnt  = final_cnt;
    r.dir        = dir;
    r.err        = e;
    r.err_rise   = err_rise;
    r.en_at_rise = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Issue one command at a negedge, push its expectation, observe until done, then score.
  task automatic do_cmd(input string tag, input logic home, input logic [W-1:0] target,
                        input exp_t e);
    exp_t got;
    exp_t want;
    logic err0;
    got = mk(0, 0, 0, '0, 1'b0, 1'b0, 0);
    chk({tag, ".ready_before"}, cmd_ready, 1);
    err0       = err;
    cmd_valid  = 1'b1;
    cmd_home   = home;
    cmd_target = target;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    got.dir   = cnt_dir;
    for (int c = 1; c <= 400; c++) begin
      if (cnt_enable) got.steps++;
      if (cnt_rst) got.rsts++;
      if (err && !err0 && got.err_rise == 0) begin
        got.err_rise   = c;
        got.en_at_rise = cnt_enable;
      end
      if (done) begin
        got.done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    got.final_cnt = count_in;
    got.err       = err;
    chk({tag, ".sb_pending"}, sb.size(), 1);
    if (sb.size() > 0) begin
      want = sb.pop_front();
      chk({tag, ".done_cycle"}, got.done_cyc, want.done_cyc);
      chk({tag, ".enable_cycles"}, got.steps, want.steps);
      chk({tag, ".rst_pulses"}, got.rsts, want.rsts);
      chk({tag, ".count"}, got.final_cnt, want.final_cnt);
      if (!home) chk({tag, ".dir"}, got.dir, want.dir);
      chk({tag, ".err"}, got.err, want.err);
      chk({tag, ".err_rise_cycle"}, got.err_rise, want.err_rise);
      chk({tag, ".enable_at_err"}, got.en_at_rise, want.en_at_rise);
    end
    @(negedge clk);
    chk({tag, ".ready_after"}, cmd_ready, 1);
    chk({tag, ".busy_after"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles with a command offered.
    rst        = 1'b0;
    cmd_valid  = 1'b1;
    cmd_target = 8'd9;
    repeat (3) begin
      @(negedge clk);
      chk("rst.cmd_ready", cmd_ready, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.cnt_enable", cnt_enable, 0);
      chk("rst.cnt_rst", cnt_rst, 0);
      chk("rst.cnt_dir", cnt_dir, 0);
      chk("rst.err", err, 0);
    end
    cmd_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rst_release.cmd_ready", cmd_ready, 1);
    chk("rst_release.busy", busy, 0);
    chk("rst_release.count", count_in, 0);

    do_cmd("up_0_5",      1'b0, 8'd5,   mk(7,   5,   0, 8'd5,   1'b1, 1'b0, 0));
    do_cmd("down_5_2",    1'b0, 8'd2,   mk(5,   3,   0, 8'd2,   1'b0, 1'b0, 0));
    do_cmd("wrap_2_250",  1'b0, 8'd250, mk(10,  8,   0, 8'd250, 1'b0, 1'b0, 0));
    do_cmd("wrap_250_0",  1'b0, 8'd0,   mk(8,   6,   0, 8'd0,   1'b1, 1'b0, 0));
    do_cmd("tie_0_128",   1'b0, 8'd128, mk(130, 128, 0, 8'd128, 1'b1, 1'b0, 0));
    do_cmd("down_128_37", 1'b0, 8'd37,  mk(93,  91,  0, 8'd37,  1'b0, 1'b0, 0));
    do_cmd("zero_37",     1'b0, 8'd37,  mk(2,   0,   0, 8'd37,  1'b1, 1'b0, 0));
    do_cmd("home_37",     1'b1, 8'd0,   mk(2,   0,   1, 8'd0,   1'b0, 1'b0, 0));
    do_cmd("up_0_10",     1'b0, 8'd10,  mk(12,  10,  0, 8'd10,  1'b1, 1'b0, 0));

    // Stuck counter: error in second RUN cycle with enable dropped, done next cycle.
    hold_fault = 1'b1;
    do_cmd("fault_10_20", 1'b0, 8'd20,  mk(3,   1,   0, 8'd10,  1'b1, 1'b1, 2));
    hold_fault = 1'b0;
    do_cmd("after_fault", 1'b0, 8'd12,  mk(4,   2,   0, 8'd12,  1'b1, 1'b1, 0));
    do_cmd("home_12",     1'b1, 8'd0,   mk(2,   0,   1, 8'd0,   1'b0, 1'b1, 0));

    // Reset during the 3rd RUN cycle of a 0 -> 50 move.
    cmd_valid  = 1'b1;
    cmd_home   = 1'b0;
    cmd_target = 8'd50;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.enable_before", cnt_enable, 1);
    chk("midrst.count_before", count_in, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.enable", cnt_enable, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.err", err, 0);
    chk("midrst.count", count_in, 3);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst.no_done", done, 0);
      chk("midrst.count_hold", count_in, 3);
    end
    do_cmd("resume_3_50", 1'b0, 8'd50,  mk(49,  47,  0, 8'd50,  1'b1, 1'b0, 0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the up/down counter (ports clk, rst, enable, dir, counter_out). It accepts move commands over a valid/ready handshake, drives the counter's enable and dir to the commanded target by the shortest modular path, and drives the counter's reset for "home" commands. It also checks that every enabled cycle moves the counter by exactly ±1, and flags a sticky error otherwise. It sits between the command source and the counter instance.

## Interface
- WIDTH, 8, counter width; must match the counter's counter_out.

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_home  in  1  1 = home (reset counter to 0); 0 = move to cmd_target
- cmd_target  in  WIDTH  move target, unsigned
- count_in  in  WIDTH  counter_out of the counter
- cnt_rst  out  1  active-high one-cycle reset pulse to the counter
- cnt_enable  out  1  counter enable
- cnt_dir  out  1  1 = up, 0 = down
- busy  out  1  command in progress (state not IDLE)
- done  out  1  one-cycle pulse when a command completes or aborts
- err  out  1  sticky step-check error

## Operation
- States: IDLE, RUN, HOME, DONE.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid && cmd_ready) captures cmd_target and cmd_home.
  - Next state is HOME if cmd_home=1, else RUN.
- Direction is fixed at accept time:
  - diff = (cmd_target − count_in) mod 2^WIDTH.
  - cnt_dir = 1 if diff ≤ 2^(WIDTH−1), else 0. The tie at exactly half goes up.
- RUN:
  - cnt_enable = (count_in != target). This is combinational from count_in, so the counter stops exactly on target.
  - When count_in == target, the next state is DONE.
  - Wrap-around is normal: a move from 2 down to 250 passes through 1, 0, 255, and so on.
- Step check: in RUN, if cnt_enable was 1 in the previous cycle, count_in must equal prev ± 1 (mod 2^WIDTH, sign per cnt_dir). On a mismatch:
  - err is set.
  - cnt_enable drops in the same cycle.
  - The next state is DONE.
- HOME:
  - cnt_rst=1 for one cycle, cnt_enable=0.
  - Next state is DONE.
  - In DONE after a home command, count_in != 0 sets err.
- DONE: done=1 for one cycle, then IDLE.
- err clears only on reset. Commands are still accepted while err=1.
- Outside RUN, cnt_enable=0. cnt_rst=0 except in HOME.
- cmd_valid is ignored when cmd_ready=0. There is no queueing.

## Timing
- Reset (rst=0 sampled at an edge):
  - State goes to IDLE.
  - cnt_enable=0, cnt_rst=0, cnt_dir=0, busy=0, done=0, err=0.
  - cmd_ready=0 while rst=0; cmd_ready=1 from the first cycle after release.
- Reset mid-RUN or mid-HOME aborts immediately, with no done pulse. The counter keeps its value.
- For a move of distance d, with accept at edge 0:
  - RUN occupies cycles 1..d+1, with cnt_enable=1 in cycles 1..d.
  - done=1 in cycle d+2.
  - cmd_ready=1 again in cycle d+3.
- d=0: no enable cycle, done in cycle 2.
- Home: cnt_rst in cycle 1, done in cycle 2, cmd_ready in cycle 3.
- Counter model for the bench: it updates on the edge following enable=1 (or cnt_rst=1); cnt_rst has priority.
- busy is high from cycle 1 through the done cycle inclusive.

## Structure
- Package counter_seq_pkg holds:
  - the state enum (IDLE, RUN, HOME, DONE);
  - the default WIDTH constant.
- One sub-module, count_step_checker:
  - inputs: clk, rst, enable, dir, count_in;
  - registers prev and the previous enable;
  - outputs a step_err flag.
- The FSM, direction computation and handshake stay in counter_seq_ctrl.

## Test plan
- Reset: hold rst=0 for 3 cycles with cmd_valid=1.
  - Required: all outputs 0, cmd_ready=0, no command accepted.
  - After release: cmd_ready=1 in the next cycle.
- Move up: count 0, target 5.
  - Required: cnt_dir=1, cnt_enable high for exactly 5 cycles, count_in=5, done at accept+7, err=0.
- Wrap and tie:
  - Count 2, target 250: cnt_dir=0, 8 steps through 0 and 255, done at accept+10.
  - Count 0, target 128: cnt_dir=1, 128 steps.
- Zero distance and home:
  - Target equal to count 37: no cnt_enable pulse, done at accept+2.
  - Then home: cnt_rst for one cycle, count_in=0, done at accept+2, err=0.
- Fault injection: counter model holds its value while enabled, count 10, target 20.
  - Required: err=1 in the second RUN cycle, cnt_enable=0 in that same cycle, done in the next cycle.
  - err stays 1 through a following good command.
- Reset mid-run: rst=0 in the 3rd RUN cycle of a 0→50 move.
  - Required: cnt_enable=0 and busy=0 after that edge, no done pulse, count_in=3.
  - The next command runs 3→50 correctly.
